// File: rtl/iic_write_ctrl.sv
// Write-only I2C master: START, N bytes MSB-first each followed by an ACK slot, STOP.
// Bytes come from an 8-bit valid/ready source; SDA is open-drain, SCL push-pull.
module iic_write_ctrl #(
  parameter int CLK_DIV = 125
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] sendBytes,
  input  logic       tvalid,
  input  logic [7:0] tdata,
  output logic       tready,
  output logic       SCL,
  inout  wire        SDA,
  output logic       done,
  output logic       ack_err
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] QMAX = CW'(CLK_DIV - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_BIT   = 3'd3;
  localparam logic [2:0] S_ACK   = 3'd4;
  localparam logic [2:0] S_STOP  = 3'd5;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] qcnt_q, qcnt_d;
  logic [1:0]    q_q, q_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          nack_q, nack_d;
  logic          ack_err_q, ack_err_d;
  logic          done_q, done_d;
  logic          scl_q, scl_d;
  logic          sdal_q, sdal_d;
  logic          wrap, timed, sda_in;

  assign sda_in  = SDA;
  assign SDA     = sdal_q ? 1'b0 : 1'bz;
  assign SCL     = scl_q;
  assign tready  = (state_q == S_LOAD);
  assign done    = done_q;
  assign ack_err = ack_err_q;

  assign wrap  = (qcnt_q == QMAX);
  assign timed = (state_q == S_START) || (state_q == S_BIT) ||
                 (state_q == S_ACK)   || (state_q == S_STOP);

  always_comb begin
    state_d   = state_q;
    qcnt_d    = qcnt_q;
    q_d       = q_q;
    bit_d     = bit_q;
    shreg_d   = shreg_q;
    cnt_d     = cnt_q;
    nack_d    = nack_q;
    ack_err_d = ack_err_q;
    done_d    = 1'b0;

    if (timed) begin
      qcnt_d = wrap ? '0 : qcnt_q + CW'(1);
      if (wrap) q_d = q_q + 2'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (tvalid && (sendBytes != 8'd0)) begin
          state_d   = S_START;
          cnt_d     = sendBytes;
          ack_err_d = 1'b0;
          qcnt_d    = '0;
          q_d       = 2'd0;
        end
      end
      S_START: if (wrap && q_q == 2'd3) state_d = S_LOAD;
      S_LOAD: begin
        // The handshake clk counts as the first clk of bit 7's Q0, so an
        // unstalled byte costs exactly 36 quarters.
        if (tvalid) begin
          shreg_d = tdata;
          bit_d   = 3'd7;
          state_d = S_BIT;
          q_d     = 2'd0;
          qcnt_d  = CW'(1);
        end
      end
      S_BIT: begin
        if (wrap && q_q == 2'd3) begin
          if (bit_q == 3'd0) state_d = S_ACK;
          else               bit_d   = bit_q - 3'd1;
        end
      end
      S_ACK: begin
        if (wrap && q_q == 2'd2) begin
          nack_d = sda_in;
          if (sda_in) ack_err_d = 1'b1;
        end
        if (wrap && q_q == 2'd3) begin
          if (nack_q) state_d = S_STOP;
          else begin
            cnt_d   = cnt_q - 8'd1;
            state_d = (cnt_q == 8'd1) ? S_STOP : S_LOAD;
          end
        end
      end
      S_STOP: begin
        if (wrap && q_q == 2'd3) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Pin levels are decoded from next state so they register on quarter edges.
  always_comb begin
    scl_d  = 1'b1;
    sdal_d = 1'b0;
    case (state_d)
      S_START: begin scl_d = ~q_d[1];      sdal_d = (q_d != 2'd0);     end
      S_LOAD:  begin scl_d = 1'b0;         sdal_d = sdal_q;            end
      S_BIT:   begin scl_d = q_d[1];       sdal_d = ~shreg_d[bit_d];   end
      S_ACK:   begin scl_d = q_d[1];       sdal_d = 1'b0;              end
      S_STOP:  begin scl_d = (q_d != 2'd0); sdal_d = ~q_d[1];          end
      default: begin scl_d = 1'b1;         sdal_d = 1'b0;              end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      qcnt_q    <= '0;
      q_q       <= 2'd0;
      bit_q     <= 3'd0;
      shreg_q   <= 8'd0;
      cnt_q     <= 8'd0;
      nack_q    <= 1'b0;
      ack_err_q <= 1'b0;
      done_q    <= 1'b0;
      scl_q     <= 1'b1;
      sdal_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      qcnt_q    <= qcnt_d;
      q_q       <= q_d;
      bit_q     <= bit_d;
      shreg_q   <= shreg_d;
      cnt_q     <= cnt_d;
      nack_q    <= nack_d;
      ack_err_q <= ack_err_d;
      done_q    <= done_d;
      scl_q     <= scl_d;
      sdal_q    <= sdal_d;
    end
  end

endmodule

// File: tb/tb_iic_write_ctrl.sv
// Bench for iic_write_ctrl: bus-level monitor plus an ACKing slave, compared
// against transaction-level expectations (bytes, handshakes, duration, flags).
module tb_iic_write_ctrl;
  localparam int CLK_DIV = 4;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] sendBytes = 8'd0;
  logic       tvalid = 1'b0;
  logic [7:0] tdata = 8'd0;
  logic       tready, SCL, done, ack_err;
  wire        SDA;
  logic       slv_low = 1'b0;

  pullup (SDA);
  assign SDA = slv_low ? 1'b0 : 1'bz;

  iic_write_ctrl #(.CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .resetn(resetn), .sendBytes(sendBytes), .tvalid(tvalid),
    .tdata(tdata), .tready(tready), .SCL(SCL), .SDA(SDA), .done(done),
    .ack_err(ack_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // Bus monitor and slave: decode START/STOP and bytes, ACK unless told to NACK.
  int         mon_starts = 0, mon_stops = 0, bitpos = 0, byte_idx = 0, cur_nack = -1;
  logic [7:0] sh = 8'd0;
  logic [7:0] bus_q[$];
  logic       p_scl = 1'b1, p_sda = 1'b1, m_sda;

  always begin
    @(posedge clk); #1;
    m_sda = (SDA === 1'b0) ? 1'b0 : 1'b1;
    if (p_scl && SCL && p_sda && !m_sda) begin
      mon_starts++; bitpos = 0; byte_idx = 0;
    end else if (p_scl && SCL && !p_sda && m_sda) begin
      mon_stops++;
    end else if (!p_scl && SCL) begin
      if (bitpos < 8) begin sh = {sh[6:0], m_sda}; bitpos++; end
      else begin bus_q.push_back(sh); byte_idx++; bitpos = 0; end
    end else if (p_scl && !SCL) begin
      slv_low = (bitpos == 8) && (byte_idx != cur_nack);
    end
    p_scl = SCL;
    p_sda = m_sda;
  end

  logic [7:0] txn_bytes[$];

  task automatic run_txn(input string nm, input int n, input int nack_idx,
                         input int stall_at, input int stall_len);
    int k, extra, exp_done, limit, cyc, done_cyc, done_cnt, hs, idx, scnt, scl_hi;
    int st0, sp0, b0;
    logic waiting, pend, exp_err;
    exp_err  = (nack_idx >= 0) && (nack_idx < n);
    k        = exp_err ? nack_idx + 1 : n;
    extra    = (stall_at > 0 && stall_at < k) ? stall_len : 0;
    // 8 + 36 quarters per byte, plus stall clks; +1 because sampled at negedge.
    exp_done = (8 + 36 * k) * CLK_DIV + extra + 1;
    limit    = exp_done + 200;
    st0 = mon_starts; sp0 = mon_stops; b0 = bus_q.size();
    cur_nack = nack_idx;
    cyc = 0; done_cyc = 0; done_cnt = 0; hs = 0; idx = 0; scnt = 0; scl_hi = 0;
    waiting = 1'b0; pend = 1'b0;
    @(negedge clk);
    sendBytes = n[7:0];
    tvalid    = 1'b1;
    tdata     = txn_bytes[0];
    while (cyc < limit && !(done_cnt > 0 && cyc >= done_cyc + 4)) begin
      @(negedge clk);
      cyc++;
      sendBytes = 8'($urandom);
      if (done) begin
        done_cnt++;
        if (done_cnt == 1) done_cyc = cyc;
        tvalid = 1'b0;
      end
      if (pend) begin
        pend = 1'b0;
        idx++;
        tdata = (idx < txn_bytes.size()) ? txn_bytes[idx] : 8'($urandom);
        if (idx == stall_at) begin tvalid = 1'b0; waiting = 1'b1; scnt = 0; end
      end
      if (waiting && tready) begin
        if (scnt < stall_len) begin scnt++; if (SCL) scl_hi++; end
        else begin tvalid = 1'b1; waiting = 1'b0; end
      end
      if (tvalid && tready) begin hs++; pend = 1'b1; end
    end
    tvalid = 1'b0;
    check($sformatf("%s.done_seen", nm), 32'(done_cnt > 0), 32'd1);
    check($sformatf("%s.done_cyc", nm), 32'(done_cyc), 32'(exp_done));
    check($sformatf("%s.done_pulses", nm), 32'(done_cnt), 32'd1);
    check($sformatf("%s.handshakes", nm), 32'(hs), 32'(k));
    check($sformatf("%s.ack_err", nm), 32'(ack_err), 32'(exp_err));
    check($sformatf("%s.starts", nm), 32'(mon_starts - st0), 32'd1);
    check($sformatf("%s.stops", nm), 32'(mon_stops - sp0), 32'd1);
    check($sformatf("%s.nbytes", nm), 32'(bus_q.size() - b0), 32'(k));
    for (int i = 0; i < k && (b0 + i) < bus_q.size(); i++)
      check($sformatf("%s.byte%0d", nm, i), 32'(bus_q[b0 + i]), 32'(txn_bytes[i]));
    if (extra > 0) check($sformatf("%s.stall_scl_high", nm), 32'(scl_hi), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int rdy, sclo, sdalo, st0, n, nk, sa;

    repeat (5) @(posedge clk);
    #1;
    check("rst.scl", 32'(SCL), 32'd1);
    check("rst.sda", 32'(SDA === 1'b1), 32'd1);
    check("rst.tready", 32'(tready), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    check("rst.ack_err", 32'(ack_err), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (3) @(negedge clk);

    txn_bytes = '{8'hA7};
    run_txn("single", 1, -1, -1, 0);
    txn_bytes = '{8'h10, 8'h11, 8'h12};
    run_txn("multi", 3, -1, -1, 0);
    txn_bytes = '{8'hC3, 8'h3C};
    run_txn("stall", 2, -1, 1, 50);
    txn_bytes = '{8'h55, 8'hAA, 8'h0F};
    run_txn("nack", 3, 0, -1, 0);
    txn_bytes = '{8'hFF, 8'h00, 8'h81};
    run_txn("n255", 255, 1, -1, 0);

    // Zero-length request: bus must stay idle and no byte is requested.
    @(negedge clk);
    st0 = mon_starts; rdy = 0; sclo = 0; sdalo = 0;
    sendBytes = 8'd0;
    tvalid    = 1'b1;
    tdata     = 8'h99;
    repeat (100) begin
      @(negedge clk);
      if (tready) rdy++;
      if (!SCL) sclo++;
      if (SDA === 1'b0) sdalo++;
    end
    tvalid = 1'b0;
    check("zero.tready", 32'(rdy), 32'd0);
    check("zero.scl_low", 32'(sclo), 32'd0);
    check("zero.sda_low", 32'(sdalo), 32'd0);
    check("zero.starts", 32'(mon_starts - st0), 32'd0);

    for (int t = 0; t < 6; t++) begin
      n  = $urandom_range(1, 4);
      nk = ($urandom_range(0, 2) == 0) ? $urandom_range(0, n - 1) : -1;
      sa = (n > 1 && $urandom_range(0, 1) == 1) ? $urandom_range(1, n - 1) : -1;
      txn_bytes.delete();
      for (int i = 0; i < n; i++) txn_bytes.push_back(8'($urandom));
      run_txn($sformatf("rnd%0d", t), n, nk, sa, $urandom_range(1, 20));
    end

    // Reset in the middle of a byte.
    @(negedge clk);
    sendBytes = 8'd2;
    tvalid    = 1'b1;
    tdata     = 8'h5A;
    repeat (60) @(negedge clk);
    tvalid = 1'b0;
    resetn = 1'b0;
    @(posedge clk);
    #1;
    check("midrst.scl", 32'(SCL), 32'd1);
    check("midrst.sda", 32'(SDA === 1'b1), 32'd1);
    check("midrst.tready", 32'(tready), 32'd0);
    check("midrst.done", 32'(done), 32'd0);
    check("midrst.ack_err", 32'(ack_err), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    sclo = 0;
    repeat (20) begin
      @(negedge clk);
      if (!SCL) sclo++;
    end
    check("midrst.idle_after", 32'(sclo), 32'd0);

    txn_bytes = '{8'h3E};
    run_txn("after_rst", 1, -1, -1, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/iic_write_ctrl.md
Name: iic_write_ctrl

Overview:
- Write-only I2C master byte engine; one transaction per request.
- Takes bytes from an AXI-Stream-style 8-bit source (tvalid/tdata/tready) and serialises them MSB-first onto SCL/SDA.
- Each transaction is START, sendBytes bytes each followed by an ACK slot, then STOP.
- Sits between a configuration sequencer (e.g. a device init ROM) and the board I2C pins.

Parameters:
- CLK_DIV, 125, clk cycles per SCL quarter-period Q. Default gives 100 kHz SCL from a 50 MHz clk. Legal range ≥2.

Ports:
- clk, input, 1: system clock (50 MHz nominal).
- resetn, input, 1: synchronous, active-low reset.
- sendBytes, input, 8: number of bytes in the transaction; latched at START.
- tvalid, input, 1: source has a byte on tdata.
- tdata, input, 8: byte to send; bit 7 is transmitted first.
- tready, output, 1: byte accepted on a cycle with tvalid & tready.
- SCL, output, 1: I2C clock, push-pull.
- SDA, inout, 1: I2C data, open-drain. Drives 0 or Z; external pull-up.
- done, output, 1: one-cycle pulse after STOP completes.
- ack_err, output, 1: sticky NACK flag; cleared at next START.

Behaviour:
- Reset (resetn=0 at posedge clk):
  - State IDLE; SCL=1; SDA released (Z); tready=0; done=0; ack_err=0.
  - Quarter counter and bit counter cleared.
  - Reset mid-transaction aborts immediately. No STOP is generated.
- Quarter timing:
  - Counter counts 0..CLK_DIV-1; one quarter Q elapses on each wrap.
  - All SCL/SDA changes occur only at quarter boundaries.
- States: IDLE, START, LOAD, BIT, ACK, STOP.
- IDLE:
  - If tvalid=1 and sendBytes≠0: latch count=sendBytes, clear ack_err, go to START.
  - If sendBytes=0: stay in IDLE; tready stays 0.
- START (4Q):
  - Q0: SDA=Z, SCL=1.
  - Q1: SDA=0, SCL=1 (START condition).
  - Q2 and Q3: SDA=0, SCL=0.
  - Then go to LOAD.
- LOAD:
  - SCL held 0; tready=1.
  - On the first cycle with tvalid & tready: shift register := tdata, tready:=0, go to BIT with bit index 7. tready is deasserted the cycle after the handshake, so exactly one byte is accepted per LOAD.
  - If tvalid=0, LOAD waits indefinitely with SCL low (clock stretch by master).
- BIT (4Q per bit, MSB first):
  - Q0: SCL=0; SDA = Z if bit=1, 0 if bit=0.
  - Q1: SCL=0.
  - Q2 and Q3: SCL=1.
  - After bit 0 go to ACK.
- ACK (4Q):
  - SDA released throughout; SCL follows the same 0,0,1,1 pattern.
  - SDA sampled on the last clk of Q2.
  - Sample 0: decrement count. If count becomes 0, go to STOP; else go to LOAD.
  - Sample 1 (NACK): set ack_err=1 and go to STOP. Remaining bytes are not requested.
- STOP (4Q):
  - Q0: SCL=0, SDA=0.
  - Q1: SCL=1, SDA=0.
  - Q2 and Q3: SCL=1, SDA=Z (STOP condition at start of Q2).
  - Then pulse done=1 for one clk and return to IDLE.
  - A new request may start on the cycle after done.
- Timing and inputs:
  - Duration with no stalls: (8 + 36·N) Q clk-quantised. For N=1 with CLK_DIV=125 that is 44·125 = 5500 clk.
  - sendBytes and tdata changes outside the latch/handshake points have no effect.
  - sendBytes=255 is legal; count is 8-bit.
- SCL is never driven high while SDA changes, except for the START and STOP edges.

Test Plan:
- Reset: hold resetn=0 for 5 clk → SCL=1, SDA=Z, tready=0, done=0, ack_err=0.
- Single byte, CLK_DIV=4, sendBytes=1, tvalid=1, tdata=8'hA7, slave ACKs:
  - START seen.
  - SDA bits sampled at SCL rising edges are 1,0,1,0,0,1,1,1.
  - ACK slot, then STOP.
  - Exactly one tready&tvalid handshake.
  - done pulses once at clk 176 after start.
  - ack_err=0.
- Multi-byte, sendBytes=3, source increments tdata 8'h10,8'h11,8'h12 on each handshake → three bytes on the bus in order, three handshakes, one STOP.
- Stall: sendBytes=2, drop tvalid for 50 clk before the second byte → SCL held 0 during the gap, then byte 2 is sent correctly.
- NACK: slave leaves SDA high in the first ACK slot with sendBytes=3 → ack_err=1, STOP immediately after that ACK, only 1 handshake.
- sendBytes=0 with tvalid=1 → bus stays idle, no handshake. A reset asserted mid-byte returns all outputs to their reset values within 1 clk.
